bus_mux_arb: RTL
================

Name: bus_mux_arb

Overview:
- N-channel successor to the 2:1 address/data muxes: selects one of NUM_CH address+data sources onto a single registered output.
- Adds a valid/ready handshake per channel, fixed-priority or round-robin arbitration, and a one-deep output register.
- Sits between multiple bus masters (fetch, load/store, DMA) and the shared memory bus port.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- CH_SEL_WIDTH, 2, width of channel index; NUM_CH <= 2**CH_SEL_WIDTH is required.
- ARB_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin.
- ADDRESS_BUS_WIDTH / DATA_BUS_WIDTH come from params.v and are not redeclared.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel request valid.
- in_ready  output  NUM_CH  per-channel accept; one-hot or zero.
- in_addr  input  NUM_CH*ADDRESS_BUS_WIDTH  flattened addresses; channel i at [i*AW +: AW].
- in_data  input  NUM_CH*DATA_BUS_WIDTH  flattened data; channel i at [i*DW +: DW].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts.
- out_addr  output  ADDRESS_BUS_WIDTH  registered selected address.
- out_data  output  DATA_BUS_WIDTH  registered selected data.
- out_chan  output  CH_SEL_WIDTH  index of the source channel of the current beat.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_addr=0, out_data=0, out_chan=0, rr_ptr=0. in_ready=0 while reset is asserted.
- load_en = !out_valid | out_ready (combinational). The output register accepts a new beat only when load_en=1.
- Grant logic is combinational and evaluated every cycle:
  - ARB_MODE=0: lowest-index channel with in_valid set.
  - ARB_MODE=1: first channel with in_valid set, searching rr_ptr, rr_ptr+1, ... modulo NUM_CH.
- in_ready[i] = load_en & grant[i]. A channel's ready never depends on its own valid beyond arbitration.
- Transfer on channel i: in_valid[i] & in_ready[i]. On the next edge:
  - out_valid=1;
  - out_addr and out_data take channel i's fields;
  - out_chan=i;
  - in ARB_MODE=1, rr_ptr becomes (i+1) mod NUM_CH, with wrap from NUM_CH-1 to 0.
- No request while load_en=1 and out_ready=1: out_valid drops to 0. out_addr, out_data and out_chan hold their last values.
- Latency: 1 cycle from input transfer to out_valid. Full throughput is one beat per cycle when out_ready stays high.
- Backpressure: out_valid=1 with out_ready=0 holds all outputs stable and drives in_ready=0 to every channel.
- Simultaneous out_ready and a new grant: the output drains and reloads in the same edge, with no bubble.
- rr_ptr changes only on a transfer, never while stalled.
- Reset asserted mid-transfer: the beat in flight is dropped. Upstream must treat it as not accepted.
- Channels >= NUM_CH within the CH_SEL_WIDTH range are never granted.

Optional Feature:
- Macro: BUS_MUX_LOCK_EN.
- With the macro defined:
  - an extra port in_lock (input, NUM_CH) is present;
  - a transfer with in_lock[i]=1 sets lock_valid and lock_ch=i;
  - while lock_valid=1, only lock_ch can be granted, regardless of ARB_MODE, and rr_ptr is frozen;
  - lock clears on the first transfer from lock_ch with in_lock=0, at which point rr_ptr updates normally;
  - reset clears lock_valid.
- Without the macro: the port, lock state and lock logic are absent, and behaviour is exactly as described above.

Decomposition:
- params.v holds ADDRESS_BUS_WIDTH and DATA_BUS_WIDTH, plus new constants ARB_FIXED=0 and ARB_RR=1.
- Sub-module rr_arbiter holds the request vector, rr_ptr and mode, and produces a one-hot grant and an encoded index.
- bus_mux_arb instantiates rr_arbiter and owns the output register and the lock state.

Test Plan:
- Reset: assert reset mid-stream with out_valid=1 -> out_valid=0, out_addr=0, out_chan=0 and in_ready=0 immediately, without waiting for a clock edge.
- Single channel: in_valid=4'b0100, addr=0x1234, out_ready=1 -> next cycle out_valid=1, out_addr=0x1234, out_chan=2; in_ready[2] high in the request cycle.
- Round-robin fairness: ARB_MODE=1, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0,... with one beat per cycle.
- Fixed priority: ARB_MODE=0, in_valid=4'b1010 held -> out_chan=1 every cycle; channel 3 is never granted.
- Backpressure: out_ready=0 for 3 cycles with requests pending -> outputs stable, in_ready=0; on release, the held beat drains and the next grant loads in the same edge.
- Lock (BUS_MUX_LOCK_EN): channel 1 sends 3 beats with in_lock=1,1,0 while channel 0 requests continuously -> out_chan=1,1,1, then 0.

Source files
------------

// File: rtl/bus_mux_arb_pkg.sv
// rtl/bus_mux_arb_pkg.sv - bus widths, arbitration mode constants and index helper for bus_mux_arb
package bus_mux_arb_pkg;

    localparam int ADDRESS_BUS_WIDTH = 16;
    localparam int DATA_BUS_WIDTH    = 32;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Next channel index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_mux_arb_rr_arbiter.sv
// rtl/bus_mux_arb_rr_arbiter.sv - combinational fixed-priority / round-robin grant (module rr_arbiter)
module rr_arbiter
    import bus_mux_arb_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CH_SEL_WIDTH = 2,
    parameter int ARB_MODE     = ARB_RR
) (
    input  logic [NUM_CH-1:0]       req,
    input  logic [CH_SEL_WIDTH-1:0] rr_ptr,
    output logic [NUM_CH-1:0]       grant,
    output logic [CH_SEL_WIDTH-1:0] grant_idx,
    output logic                    grant_any
);

    localparam int NSLOT = 1 << CH_SEL_WIDTH;

    logic [NSLOT-1:0] req_ext;
    logic [NSLOT-1:0] grant_ext;

    // Slots beyond NUM_CH are padded with zero requests so they can never win.
    assign req_ext = NSLOT'(req);
    assign grant   = grant_ext[NUM_CH-1:0];

    always_comb begin
        int base;
        int sum;
        logic [CH_SEL_WIDTH-1:0] idx;
        grant_ext = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        base      = (ARB_MODE == ARB_RR) ? int'(rr_ptr) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = base + k;
            if (sum >= NUM_CH) sum = sum - NUM_CH;
            idx = CH_SEL_WIDTH'(sum);
            if (!grant_any && req_ext[idx]) begin
                grant_ext[idx] = 1'b1;
                grant_idx      = idx;
                grant_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_mux_arb.sv
// rtl/bus_mux_arb.sv - NUM_CH:1 arbitrated address/data mux with one-deep output register
// Optional channel lock (in_lock port) is built when BUS_MUX_LOCK_EN is defined.
module bus_mux_arb
    import bus_mux_arb_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CH_SEL_WIDTH = 2,
    parameter int ARB_MODE     = ARB_RR
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CH-1:0]                     in_valid,
`ifdef BUS_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]                     in_lock,
`endif
    output logic [NUM_CH-1:0]                     in_ready,
    input  logic [NUM_CH*ADDRESS_BUS_WIDTH-1:0]   in_addr,
    input  logic [NUM_CH*DATA_BUS_WIDTH-1:0]      in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ADDRESS_BUS_WIDTH-1:0]          out_addr,
    output logic [DATA_BUS_WIDTH-1:0]             out_data,
    output logic [CH_SEL_WIDTH-1:0]               out_chan
);

    localparam int AW = ADDRESS_BUS_WIDTH;
    localparam int DW = DATA_BUS_WIDTH;

    logic                    load_en;
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH-1:0]       grant;
    logic [CH_SEL_WIDTH-1:0] grant_idx;
    logic                    grant_any;
    logic [CH_SEL_WIDTH-1:0] rr_ptr;
    logic [AW-1:0]           sel_addr;
    logic [DW-1:0]           sel_data;
    logic                    ptr_upd;

`ifdef BUS_MUX_LOCK_EN
    logic                    lock_valid;
    logic [CH_SEL_WIDTH-1:0] lock_ch;
    logic [NUM_CH-1:0]       lock_mask;
    logic                    lock_req;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            lock_mask[i] = (lock_ch == CH_SEL_WIDTH'(i));
        end
    end

    assign req      = lock_valid ? (in_valid & lock_mask) : in_valid;
    assign lock_req = |(grant & in_lock);
    // Pointer stays frozen across locked beats; the unlocking beat advances it.
    assign ptr_upd  = !(lock_valid && lock_req);
`else
    assign req      = in_valid;
    assign ptr_upd  = 1'b1;
`endif

    rr_arbiter #(
        .NUM_CH       (NUM_CH),
        .CH_SEL_WIDTH (CH_SEL_WIDTH),
        .ARB_MODE     (ARB_MODE)
    ) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign load_en  = !out_valid || out_ready;
    assign in_ready = (load_en && !reset) ? grant : '0;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | in_addr[i*AW +: AW];
                sel_data = sel_data | in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            out_chan   <= '0;
            rr_ptr     <= '0;
`ifdef BUS_MUX_LOCK_EN
            lock_valid <= 1'b0;
            lock_ch    <= '0;
`endif
        end else if (load_en) begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_addr <= sel_addr;
                out_data <= sel_data;
                out_chan <= grant_idx;
                if (ARB_MODE == ARB_RR && ptr_upd) begin
                    rr_ptr <= CH_SEL_WIDTH'(wrap_inc(int'(grant_idx), NUM_CH));
                end
`ifdef BUS_MUX_LOCK_EN
                lock_valid <= lock_req;
                lock_ch    <= grant_idx;
`endif
            end
        end
    end

endmodule
